prover_compute_w0_seq: RTL and testbench
========================================

Name: prover_compute_w0_seq

Overview:
- Sequential prover helper. For each of `ninbits` coordinates, computes the point on the line w1 + t·(w2 − w1) at t = tau over the prime field F_q: w0[i] = w1[i] + w2_m_w1[i]·tau mod q.
- Also produces m_w0_p1 = 1 − w0[i] mod q.
- Streams results one coordinate at a time, highest index first, with a ready/continue handshake.
- Sits in the sumcheck prover, between the line-reduction step and the downstream consumer of w0.

Parameters:
- ninbits, 8, number of coordinates (array depth of w1, w2_m_w1); ≥1.
- Field width F_NBITS and modulus F_Q come from the shared field package; they are not module parameters.

Ports:
- clk  in  1  rising-edge clock.
- rstb  in  1  synchronous reset, active-high (asserted = 1).
- en  in  1  start request; sampled only in IDLE.
- cont  in  1  consumer acknowledge; advances to the next coordinate.
- w1  in  [F_NBITS-1:0] x ninbits  line base point, unpacked array.
- w2_m_w1  in  [F_NBITS-1:0] x ninbits  line direction (w2 − w1), unpacked array.
- tau  in  F_NBITS  evaluation point.
- ready  out  1  high in IDLE; no run in progress.
- w0_ready  out  1  w0/m_w0_p1 hold a valid result for the current index.
- w0  out  F_NBITS  current w0[idx].
- m_w0_p1  out  F_NBITS  current (1 − w0[idx]) mod q.

Behaviour:
- Reset (rstb=1 at posedge): state IDLE; ready=1, w0_ready=0, w0=0, m_w0_p1=0, idx=ninbits-1. Reset mid-run aborts the run with no output.
- States and transitions:
  - IDLE: ready=1. en=1 → idx=ninbits-1, ready=0, go to MUL.
  - MUL: start the field multiplier on w2_m_w1[idx]·tau; wait for its done, then go to ADD.
  - ADD: w0 = (prod + w1[idx]) mod q; m_w0_p1 = (q + 1 − w0) mod q. Both register on the same edge; go to OUT.
  - OUT: w0_ready=1; w0 and m_w0_p1 held stable.
    - cont=1 with idx>0 → w0_ready=0 next cycle, idx−1, go to MUL.
    - cont=1 with idx=0 → w0_ready=0, ready=1, go to IDLE.
- Ordering: results emerge idx = ninbits-1 down to 0.
- cont is level-sensitive and acts only in OUT. cont held high during MUL/ADD is ignored. A consumer may assert cont the cycle after seeing w0_ready.
- en outside IDLE is ignored. en and rstb both high → reset wins.
- Inputs w1, w2_m_w1, tau are not latched and must stay stable from the en cycle until ready returns high.
- Arithmetic:
  - All operands < q.
  - Addition: sum in F_NBITS+1 bits, conditionally subtract q.
  - Negation: ~w0 + F_Q_P2_MI (≡ q + 2 − 2^F_NBITS), reduced mod q. This yields 0 when w0=1 and 1 when w0=0.
- Latency per coordinate: multiplier latency + 2 cycles (ADD, then OUT visible), plus 1 cycle after cont.
- w0/m_w0_p1 retain the last values in IDLE.

Decomposition:
- Shared field package: F_NBITS, F_Q, F_Q_P2_MI, and add/sub/negate mod-q functions.
- One sub-module: field_multiplier (start/done handshake, operands < q, output a·b mod q). It is reused elsewhere in the prover.
- The remainder (FSM, index counter, adder, negation) lives in this block.

Test Plan:
- Basic, ninbits=8: w1[7]=5, w2_m_w1[7]=3, tau=7, pulse en → first w0_ready shows w0=26, m_w0_p1=q−25. After cont, index 6 follows.
- tau=0, all coords: every w0[i]=w1[i]. With w1[i]=1, m_w0_p1=0; with w1[i]=0, m_w0_p1=1.
- Wrap: w1=0, w2_m_w1=q−1, tau=1 → w0=q−1, m_w0_p1=2. With w1=1 on the same inputs → w0=0, m_w0_p1=1.
- Handshake: hold cont=0 for 10 cycles in OUT → w0_ready and outputs stable. After 8 acknowledged results, ready rises. 7 back-to-back random runs match the software model (w2_m_w1·tau + w1 mod q).
- Ignored inputs: en pulsed mid-run and cont pulsed during MUL → no effect on sequence or count.
- Reset mid-run, asserted during OUT of index 4 → next cycle ready=1, w0_ready=0, outputs 0. A new en restarts at index 7.

Source files
------------

// File: rtl/prover_compute_w0_seq_pkg.sv
// Shared prime-field definitions for the sumcheck prover: width, modulus and
// small mod-q helpers. Every operand passed to these helpers is assumed < F_Q.
package prover_compute_w0_seq_pkg;

    localparam int F_NBITS = 16;
    localparam logic [F_NBITS-1:0] F_Q = 16'd65521;
    // q + 2 - 2^F_NBITS, kept in F_NBITS bits so that ~w + F_Q_P2_MI wraps to q + 1 - w
    localparam logic [F_NBITS-1:0] F_Q_P2_MI = F_Q + 16'd2;

    function automatic logic [F_NBITS-1:0] add_mod(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

    function automatic logic [F_NBITS-1:0] sub_mod(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[F_NBITS]) d = d + {1'b0, F_Q};
        return d[F_NBITS-1:0];
    endfunction

    // Returns (1 - w) mod q; only w = 0 and w = 1 land at or above q before reduction.
    function automatic logic [F_NBITS-1:0] one_minus_mod(input logic [F_NBITS-1:0] w);
        logic [F_NBITS-1:0] t;
        t = ~w + F_Q_P2_MI;
        if (t >= F_Q) t = t - F_Q;
        return t;
    endfunction

endpackage

// File: rtl/prover_compute_w0_seq_if.sv
// Handshake and data bundle between the line-reduction stage and the w0 consumer.
interface prover_compute_w0_seq_if #(parameter int ninbits = 8);
    import prover_compute_w0_seq_pkg::*;

    logic               en;
    logic               cont;
    logic [F_NBITS-1:0] w1      [ninbits];
    logic [F_NBITS-1:0] w2_m_w1 [ninbits];
    logic [F_NBITS-1:0] tau;
    logic               ready;
    logic               w0_ready;
    logic [F_NBITS-1:0] w0;
    logic [F_NBITS-1:0] m_w0_p1;

    modport master (
        output en, cont, w1, w2_m_w1, tau,
        input  ready, w0_ready, w0, m_w0_p1
    );

    modport slave (
        input  en, cont, w1, w2_m_w1, tau,
        output ready, w0_ready, w0, m_w0_p1
    );

endinterface

// File: rtl/prover_compute_w0_seq_field_multiplier.sv
// Bit-serial mod-q multiplier (MSB-first double-and-add), one bit of b per cycle.
// start captures the operands; done pulses once when prod holds a*b mod q.
module field_multiplier
    import prover_compute_w0_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic               done,
    output logic [F_NBITS-1:0] prod
);

    localparam int CNT_W = $clog2(F_NBITS + 1);

    logic [F_NBITS-1:0] a_r;
    logic [F_NBITS-1:0] b_r;
    logic [F_NBITS-1:0] acc;
    logic [F_NBITS-1:0] acc_step;
    logic [CNT_W-1:0]   cnt;
    logic               busy;

    always_comb begin
        acc_step = add_mod(acc, acc);
        if (b_r[F_NBITS-1]) acc_step = add_mod(acc_step, a_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r  <= a;
                b_r  <= b;
                acc  <= '0;
                cnt  <= CNT_W'(F_NBITS);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= acc_step;
                b_r <= b_r << 1;
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign prod = acc;

endmodule

// File: rtl/prover_compute_w0_seq.sv
// Streams w0[i] = w1[i] + w2_m_w1[i]*tau mod q and (1 - w0[i]) mod q,
// highest index first, one coordinate per cont acknowledge.
module prover_compute_w0_seq
    import prover_compute_w0_seq_pkg::*;
#(
    parameter int ninbits = 8
) (
    input  logic                   clk,
    input  logic                   rstb,
    prover_compute_w0_seq_if.slave io
);

    localparam int IDX_W = (ninbits > 1) ? $clog2(ninbits) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ninbits - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic               mul_start;
    logic               mul_done;
    logic [F_NBITS-1:0] prod;
    logic [F_NBITS-1:0] sum_w0;
    logic [F_NBITS-1:0] w0_r;
    logic [F_NBITS-1:0] m_w0_p1_r;

    field_multiplier u_mul (
        .clk   (clk),
        .rst   (rstb),
        .start (mul_start),
        .a     (io.w2_m_w1[idx]),
        .b     (io.tau),
        .done  (mul_done),
        .prod  (prod)
    );

    assign sum_w0 = add_mod(prod, io.w1[idx]);

    // mul_start is a one-cycle pulse issued together with the move into MUL,
    // so the multiplier sees the already-updated idx when it captures operands.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state     <= S_IDLE;
            idx       <= IDX_LAST;
            mul_start <= 1'b0;
            w0_r      <= '0;
            m_w0_p1_r <= '0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (io.en) begin
                        idx       <= IDX_LAST;
                        mul_start <= 1'b1;
                        state     <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (mul_done) state <= S_ADD;
                end
                S_ADD: begin
                    w0_r      <= sum_w0;
                    m_w0_p1_r <= one_minus_mod(sum_w0);
                    state     <= S_OUT;
                end
                default: begin
                    if (io.cont) begin
                        if (idx == '0) begin
                            state <= S_IDLE;
                        end else begin
                            idx       <= idx - IDX_W'(1);
                            mul_start <= 1'b1;
                            state     <= S_MUL;
                        end
                    end
                end
            endcase
        end
    end

    assign io.ready    = (state == S_IDLE);
    assign io.w0_ready = (state == S_OUT);
    assign io.w0       = w0_r;
    assign io.m_w0_p1  = m_w0_p1_r;

endmodule

// File: tb/tb_prover_compute_w0_seq.sv
// Self-checking bench for prover_compute_w0_seq: vector table, hand-written
// handshake/reset sequences and random runs against a plain-arithmetic model.
module tb_prover_compute_w0_seq;
    import prover_compute_w0_seq_pkg::*;

    localparam int N = 8;
    localparam longint unsigned Q = longint'(F_Q);

    typedef struct {
        logic [F_NBITS-1:0] w1;
        logic [F_NBITS-1:0] w2m;
        logic [F_NBITS-1:0] tau;
        logic [F_NBITS-1:0] ew0;
        logic [F_NBITS-1:0] em;
    } vec_t;

    logic clk;
    logic rstb;
    int   total;
    int   bad;

    logic [F_NBITS-1:0] exp_w0 [N];
    logic [F_NBITS-1:0] exp_m  [N];
    vec_t               vecs   [7];

    prover_compute_w0_seq_if #(.ninbits(N)) pi ();

    prover_compute_w0_seq #(.ninbits(N)) dut (
        .clk  (clk),
        .rstb (rstb),
        .io   (pi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [F_NBITS-1:0] ref_w0(input longint unsigned w1,
                                                  input longint unsigned d,
                                                  input longint unsigned t);
        return F_NBITS'((w1 + d * t) % Q);
    endfunction

    function automatic logic [F_NBITS-1:0] ref_m(input longint unsigned w0);
        return F_NBITS'((Q + 1 - w0) % Q);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int i, input logic [F_NBITS-1:0] w1,
                                  input logic [F_NBITS-1:0] d);
        pi.w1[i]      = w1;
        pi.w2_m_w1[i] = d;
    endtask

    task automatic fill_model();
        for (int i = 0; i < N; i++) begin
            exp_w0[i] = ref_w0(longint'(pi.w1[i]), longint'(pi.w2_m_w1[i]), longint'(pi.tau));
            exp_m[i]  = ref_m(longint'(exp_w0[i]));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++)
            apply_stimulus(i, F_NBITS'($urandom % 32'(F_Q)), F_NBITS'($urandom % 32'(F_Q)));
        pi.tau = ($urandom_range(0, 5) == 0) ? '0 : F_NBITS'($urandom % 32'(F_Q));
    endtask

    // One full run; abort_at >= 0 resets the block when that index reaches OUT.
    task automatic run_sequence(input int abort_at, input bit hold_first, input bit inject);
        int cyc;
        @(negedge clk);
        pi.en = 1'b1;
        @(negedge clk);
        pi.en = 1'b0;
        check_output("busy", 32'(pi.ready), 32'd0);
        for (int k = N - 1; k >= 0; k--) begin
            cyc = 0;
            while (!pi.w0_ready && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
            if (!pi.w0_ready) begin
                check_output($sformatf("timeout_idx%0d", k), 32'd0, 32'd1);
                return;
            end
            if (k == abort_at) begin
                rstb = 1'b1;
                @(negedge clk);
                rstb = 1'b0;
                check_output("abort_ready", 32'(pi.ready), 32'd1);
                check_output("abort_w0_ready", 32'(pi.w0_ready), 32'd0);
                check_output("abort_w0", 32'(pi.w0), 32'd0);
                check_output("abort_m", 32'(pi.m_w0_p1), 32'd0);
                return;
            end
            check_output($sformatf("w0[%0d]", k), 32'(pi.w0), 32'(exp_w0[k]));
            check_output($sformatf("m_w0_p1[%0d]", k), 32'(pi.m_w0_p1), 32'(exp_m[k]));
            if (hold_first && k == N - 1) begin
                repeat (10) begin
                    @(negedge clk);
                    check_output("hold_w0_ready", 32'(pi.w0_ready), 32'd1);
                    check_output("hold_w0", 32'(pi.w0), 32'(exp_w0[k]));
                    check_output("hold_m", 32'(pi.m_w0_p1), 32'(exp_m[k]));
                end
            end
            pi.cont = 1'b1;
            @(negedge clk);
            pi.cont = 1'b0;
            check_output("ack_drop", 32'(pi.w0_ready), 32'd0);
            if (inject && k > 0) begin
                pi.en   = 1'b1;
                pi.cont = 1'b1;
                @(negedge clk);
                @(negedge clk);
                pi.en   = 1'b0;
                pi.cont = 1'b0;
            end
        end
        check_output("ready_end", 32'(pi.ready), 32'd1);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rstb    = 1'b1;
        pi.en   = 1'b0;
        pi.cont = 1'b0;
        pi.tau  = '0;
        for (int i = 0; i < N; i++) apply_stimulus(i, '0, '0);

        vecs[0] = '{w1: 16'd5,     w2m: 16'd3,     tau: 16'd7,     ew0: 16'd26,    em: 16'd65496};
        vecs[1] = '{w1: 16'd1,     w2m: 16'd123,   tau: 16'd0,     ew0: 16'd1,     em: 16'd0};
        vecs[2] = '{w1: 16'd0,     w2m: 16'd999,   tau: 16'd0,     ew0: 16'd0,     em: 16'd1};
        vecs[3] = '{w1: 16'd0,     w2m: 16'd65520, tau: 16'd1,     ew0: 16'd65520, em: 16'd2};
        vecs[4] = '{w1: 16'd1,     w2m: 16'd65520, tau: 16'd1,     ew0: 16'd0,     em: 16'd1};
        vecs[5] = '{w1: 16'd65520, w2m: 16'd65520, tau: 16'd65520, ew0: 16'd0,     em: 16'd1};
        vecs[6] = '{w1: 16'd2,     w2m: 16'd2,     tau: 16'd3,     ew0: 16'd8,     em: 16'd65514};

        repeat (2) @(negedge clk);
        rstb = 1'b0;
        check_output("rst_ready", 32'(pi.ready), 32'd1);
        check_output("rst_w0_ready", 32'(pi.w0_ready), 32'd0);
        check_output("rst_w0", 32'(pi.w0), 32'd0);
        check_output("rst_m", 32'(pi.m_w0_p1), 32'd0);

        for (int v = 0; v < 7; v++) begin
            pi.tau = vecs[v].tau;
            for (int i = 0; i < N; i++) begin
                apply_stimulus(i, vecs[v].w1, vecs[v].w2m);
                exp_w0[i] = vecs[v].ew0;
                exp_m[i]  = vecs[v].em;
            end
            run_sequence(-1, 1'b0, 1'b0);
        end

        // Basic case with distinct lower coordinates, held OUT and ignored en/cont.
        fill_random();
        pi.tau = 16'd7;
        apply_stimulus(N - 1, 16'd5, 16'd3);
        fill_model();
        exp_w0[N-1] = 16'd26;
        exp_m[N-1]  = F_Q - 16'd25;
        run_sequence(-1, 1'b1, 1'b1);

        for (int r = 0; r < 7; r++) begin
            fill_random();
            fill_model();
            run_sequence(-1, 1'b0, 1'b0);
        end

        fill_random();
        fill_model();
        run_sequence(4, 1'b0, 1'b0);
        run_sequence(-1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
